// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder built from one full-adder cell.
// Operands are shifted in LSB first, one bit per clock. A carry flip-flop
// closes the carry loop. The start/busy/done handshake frames each add.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a signed-overflow output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one sum bit per clock, LSB first, for WIDTH clocks
// DONE  | one-cycle done pulse; sum/carryout became valid on entry

module structural_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;
  logic g;
  logic t;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign g    = a & b;
  assign t    = p & cin;
  assign cout = g | t;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic fa_sum;
  logic fa_cout;
  logic accept;
  logic run;
  logic last_bit;

  structural_full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (cy),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  assign accept   = (state == S_IDLE) && start;
  assign run      = (state == S_RUN);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register; reset aborts any add in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, serial shifting, and result registers. The result is
  // loaded from the final adder bit on the same edge that enters DONE, so
  // sum/carryout are already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      cy   <= carryin;
      cnt  <= '0;
    end else if (run) begin
      sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      cy     <= fa_cout;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        sum      <= {fa_sum, sum_sr[WIDTH-1:1]};
        carryout <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (run && last_bit) begin
      overflow <= cy ^ fa_cout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl at WIDTH=8.
// Build with SERIAL_ADD_OVF_EN defined to also check the overflow output.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;
`ifdef SERIAL_ADD_OVF_EN
  logic         overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  always #100 clk = ~clk;

  initial begin
    #(200 * 40000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADD_OVF_EN
    check(tag, 32'(overflow), 32'(exp));
`else
    if (exp === 1'bx) $display("unexpected x in %s", tag);
`endif
  endtask

  // One directed add: accept on the edge after this call's first negedge.
  // Operands are scrambled after accept; inj>0 also pulses start mid-run.
  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int inj);
    @(negedge clk);
    a = ta; b = tb; carryin = tc; start = 1'b1;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        a = ~ta; b = ~tb; carryin = ~tc;
      end
      if (inj != 0 && c == inj) begin
        a = 8'hAA; b = 8'h55; carryin = 1'b1; start = 1'b1;
      end
      if (c <= W) begin
        check({tag, "_busy_done"}, 32'({busy, done}), 32'(2'b10));
        if (c == 1 || c == W) begin
          check({tag, "_hold_sum"}, 32'({carryout, sum}), 32'({last_cout, last_sum}));
        end
      end else if (c == W + 1) begin
        check({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
        check({tag, "_result"}, 32'({carryout, sum}), 32'({ec, es}));
        check_ovf({tag, "_ovf"}, eo);
      end else begin
        check({tag, "_after"}, 32'({busy, done, carryout, sum}), 32'({2'b00, ec, es}));
      end
    end
    start = 1'b0;
    last_sum = es; last_cout = ec; last_ovf = eo;
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   gold;
    logic         govf;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; carryin = 1'b0;
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({busy, done, carryout, sum}), 32'(0));
    check_ovf("reset_ovf", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({busy, done, carryout, sum}), 32'(0));

    run_add("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
    run_add("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_add("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3);
    run_add("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    run_add("add_aa_55_c1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);

    // Held result survives idle cycles.
    repeat (4) @(negedge clk);
    check("idle_hold", 32'({busy, done, carryout, sum}), 32'({2'b00, last_cout, last_sum}));
    check_ovf("idle_hold_ovf", last_ovf);

    // Reset in cycle 4 of a run: no done pulse, everything back to zero.
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; carryin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'({busy, done}), 32'(2'b10));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_zero", 32'({busy, done, carryout, sum}), 32'(0));
    check_ovf("post_reset_ovf", 1'b0);
    done_seen = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("aborted_no_done", 32'(done_seen), 32'(0));
    check("aborted_idle", 32'({busy, done, carryout, sum}), 32'(0));

    // Back-to-back random adds with start held high: period must be W+2.
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a = ra; b = rb; carryin = rc; start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      gold = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      govf = (ra[W-1] == rb[W-1]) && (gold[W-1] != ra[W-1]);
      for (int c = 1; c <= W + 2; c++) begin
        @(negedge clk);
        if (c == W) begin
          check("rand_busy", 32'({busy, done}), 32'(2'b10));
        end else if (c == W + 1) begin
          check("rand_result", 32'({done, carryout, sum}), 32'({1'b1, gold}));
          check_ovf("rand_ovf", govf);
        end else if (c == W + 2) begin
          if (i < 999) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a = ra; b = rb; carryin = rc;
          end else begin
            start = 1'b0;
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
